segre_mem_arbiter: RTL and testbench
====================================

Name: segre_mem_arbiter

Overview:
- Sits between the icache/dcache miss paths and the single main-memory port.
- Accepts line requests from both caches into an in-order FIFO of ARB_BUF_SIZE entries, tagged with cache_id_e (ICACHE/DCACHE).
- Issues one memory transaction at a time and routes each read response back to the originating cache.
- Writes (dcache evictions) complete without a response.

Parameters:
ARB_BUF_SIZE, 16, FIFO depth; must be a power of two (pointers wrap mod depth)
ADDR_SIZE, 32, request address width
CACHE_LINE_SIZE_BITS, 128, line payload width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
ic_req_valid_i  in  1  icache read request
ic_addr_i  in  ADDR_SIZE  icache line address
ic_req_ready_o  out  1  icache request accepted this cycle when high with valid
dc_req_valid_i  in  1  dcache request
dc_rd_i  in  1  dcache read (refill)
dc_wr_i  in  1  dcache write (eviction)
dc_addr_i  in  ADDR_SIZE  dcache line address
dc_line_i  in  CACHE_LINE_SIZE_BITS  write data
dc_req_ready_o  out  1  dcache request accepted
mem_req_valid_o  out  1  request to memory
mem_rd_o  out  1  memory read
mem_wr_o  out  1  memory write
mem_addr_o  out  ADDR_SIZE  memory address
mem_line_o  out  CACHE_LINE_SIZE_BITS  memory write data
mem_req_ready_i  in  1  memory accepts request
mem_rsp_valid_i  in  1  memory read data valid
mem_rsp_line_i  in  CACHE_LINE_SIZE_BITS  memory read data
ic_rsp_valid_o  out  1  one-cycle pulse, refill line for icache
ic_rsp_line_o  out  CACHE_LINE_SIZE_BITS  icache refill data
dc_rsp_valid_o  out  1  one-cycle pulse, refill line for dcache
dc_rsp_line_o  out  CACHE_LINE_SIZE_BITS  dcache refill data

Behaviour:
- Reset:
  - FIFO empty: rd_ptr = wr_ptr = 0, count = 0; count is ARB_PTR_SIZE+1 bits.
  - FSM in IDLE.
  - All outputs 0; ready outputs 0 during reset.
- Enqueue:
  - At most one push per cycle. A requester holds valid and payload stable until accepted.
  - Grant with no fairness: dcache has priority over icache.
  - dc_req_ready_o = !full && !rst_i. ic_req_ready_o = !full && !rst_i && !dc_req_valid_i.
  - full means count == ARB_BUF_SIZE, evaluated on the registered count. A pop in the same cycle does not free a slot.
  - Entry fields: {cache_id, rd, wr, addr, line}. Icache entries carry rd=1, wr=0, line=0.
  - Dcache request with dc_rd_i == dc_wr_i: acknowledged (ready high) but not enqueued.
- Issue FSM:
  - IDLE: if count != 0, go to REQ.
  - REQ: mem_req_valid_o = 1; mem_rd_o, mem_wr_o, mem_addr_o and mem_line_o driven from the head entry.
    - On mem_req_ready_i with rd=1: go to WAIT_RSP.
    - On mem_req_ready_i with wr=1: pop the head, go to IDLE.
    - Without mem_req_ready_i: stay in REQ with outputs stable.
  - WAIT_RSP: mem_req_valid_o = 0. On mem_rsp_valid_i:
    - Register mem_rsp_line_i into the response line of the head's cache_id.
    - Pulse that cache's rsp_valid for exactly one cycle, in the cycle after mem_rsp_valid_i.
    - Pop the head, go to IDLE.
  - mem_rsp_valid_i outside WAIT_RSP is ignored.
- mem_* outputs are 0 outside REQ.
- Responses are always delivered in issue order (single outstanding transaction).
- Minimum latency: request accepted in cycle N gives mem_req_valid_o high in cycle N+2.
- Simultaneous push and pop: both take effect; count unchanged; pointers wrap from ARB_BUF_SIZE-1 to 0.
- rsp_line outputs hold their value until the next response to the same cache.
- Reset mid-transaction: in-flight request and all queued entries are discarded. A later stray mem_rsp_valid_i is ignored; no response pulses.

Optional Feature:
SEGRE_ARB_ROUND_ROBIN_EN
- Defined:
  - When both caches are valid in the same cycle, the grant alternates.
  - A 1-bit last_grant register (reset = ICACHE, so dcache wins first) gives priority to the cache not granted last.
  - last_grant updates only on an accepted push.
  - ic_req_ready_o and dc_req_ready_o follow that grant; neither is high while full.
- Undefined: fixed dcache priority as above.

Test Plan:
- Single icache read at addr 0x0000_1040; mem_req_ready_i=1, response 0xDEADBEEF_... 3 cycles later -> mem_req_valid_o with mem_rd_o=1 at N+2; ic_rsp_valid_o pulses once with that line; dc_rsp_valid_o stays 0.
- Dcache write at 0x200 followed by icache read at 0x300 -> memory sees write 0x200 then read 0x300 in order; no response for the write; icache refill delivered.
- Hold mem_req_ready_i=0 and push 16 dcache reads -> count=16, both ready outputs 0 on the 17th attempt; release memory -> all 16 responses on dc_rsp_valid_o in FIFO order, pointers wrap.
- Both caches valid every cycle for 4 cycles -> without macro: dcache granted 4 times, icache starved; with SEGRE_ARB_ROUND_ROBIN_EN: grants D,I,D,I.
- Assert rst_i for 1 cycle while in WAIT_RSP with 3 queued entries -> then drive mem_rsp_valid_i -> no rsp pulses, mem_req_valid_o=0, FIFO empty.
- Dcache request with rd=wr=1 -> ready high, count unchanged, no memory request issued.

Source files
------------

// File: rtl/segre_mem_arbiter.sv
// Memory-port arbiter for icache/dcache line requests: in-order FIFO, one transaction in flight.
// Optional: define SEGRE_ARB_ROUND_ROBIN_EN for alternating grants when both caches request together.
module segre_mem_arbiter #(
  parameter int ARB_BUF_SIZE         = 16,
  parameter int ADDR_SIZE            = 32,
  parameter int CACHE_LINE_SIZE_BITS = 128
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            ic_req_valid_i,
  input  logic [ADDR_SIZE-1:0]            ic_addr_i,
  output logic                            ic_req_ready_o,
  input  logic                            dc_req_valid_i,
  input  logic                            dc_rd_i,
  input  logic                            dc_wr_i,
  input  logic [ADDR_SIZE-1:0]            dc_addr_i,
  input  logic [CACHE_LINE_SIZE_BITS-1:0] dc_line_i,
  output logic                            dc_req_ready_o,
  output logic                            mem_req_valid_o,
  output logic                            mem_rd_o,
  output logic                            mem_wr_o,
  output logic [ADDR_SIZE-1:0]            mem_addr_o,
  output logic [CACHE_LINE_SIZE_BITS-1:0] mem_line_o,
  input  logic                            mem_req_ready_i,
  input  logic                            mem_rsp_valid_i,
  input  logic [CACHE_LINE_SIZE_BITS-1:0] mem_rsp_line_i,
  output logic                            ic_rsp_valid_o,
  output logic [CACHE_LINE_SIZE_BITS-1:0] ic_rsp_line_o,
  output logic                            dc_rsp_valid_o,
  output logic [CACHE_LINE_SIZE_BITS-1:0] dc_rsp_line_o
);

  localparam int ARB_PTR_SIZE = $clog2(ARB_BUF_SIZE);
  localparam logic [ARB_PTR_SIZE:0] BUF_DEPTH = ARB_BUF_SIZE[ARB_PTR_SIZE:0];

  typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} cache_id_e;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] REQ      = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;

  cache_id_e                       buf_id   [ARB_BUF_SIZE];
  logic                            buf_rd   [ARB_BUF_SIZE];
  logic                            buf_wr   [ARB_BUF_SIZE];
  logic [ADDR_SIZE-1:0]            buf_addr [ARB_BUF_SIZE];
  logic [CACHE_LINE_SIZE_BITS-1:0] buf_line [ARB_BUF_SIZE];

  logic [ARB_PTR_SIZE-1:0] rd_ptr;
  logic [ARB_PTR_SIZE-1:0] wr_ptr;
  logic [ARB_PTR_SIZE:0]   count;
  logic [1:0]              state;
  logic [1:0]              state_nxt;

  logic full;
  logic dc_fire;
  logic ic_fire;
  logic dc_push;
  logic push;
  logic pop;
  logic in_req;

  cache_id_e                       head_id;
  logic                            head_rd;
  logic                            head_wr;
  logic [ADDR_SIZE-1:0]            head_addr;
  logic [CACHE_LINE_SIZE_BITS-1:0] head_line;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot for a push.
  assign full = (count == BUF_DEPTH);

`ifdef SEGRE_ARB_ROUND_ROBIN_EN
  cache_id_e last_grant;

  assign dc_req_ready_o = !full && !rst_i && (!ic_req_valid_i || last_grant == ICACHE);
  assign ic_req_ready_o = !full && !rst_i && (!dc_req_valid_i || last_grant == DCACHE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant <= ICACHE;
    end else if (push) begin
      if (dc_push) last_grant <= DCACHE;
      else         last_grant <= ICACHE;
    end
  end
`else
  assign dc_req_ready_o = !full && !rst_i;
  assign ic_req_ready_o = !full && !rst_i && !dc_req_valid_i;
`endif

  assign dc_fire = dc_req_valid_i && dc_req_ready_o;
  assign ic_fire = ic_req_valid_i && ic_req_ready_o;
  // A dcache request that is neither a pure read nor a pure write is acknowledged and dropped.
  assign dc_push = dc_fire && (dc_rd_i != dc_wr_i);
  assign push    = dc_push || ic_fire;

  assign head_id   = buf_id[rd_ptr];
  assign head_rd   = buf_rd[rd_ptr];
  assign head_wr   = buf_wr[rd_ptr];
  assign head_addr = buf_addr[rd_ptr];
  assign head_line = buf_line[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push) begin
      if (dc_fire) begin
        buf_id[wr_ptr]   <= DCACHE;
        buf_rd[wr_ptr]   <= dc_rd_i;
        buf_wr[wr_ptr]   <= dc_wr_i;
        buf_addr[wr_ptr] <= dc_addr_i;
        buf_line[wr_ptr] <= dc_line_i;
      end else begin
        buf_id[wr_ptr]   <= ICACHE;
        buf_rd[wr_ptr]   <= 1'b1;
        buf_wr[wr_ptr]   <= 1'b0;
        buf_addr[wr_ptr] <= ic_addr_i;
        buf_line[wr_ptr] <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) state_nxt = REQ;
      end
      REQ: begin
        if (mem_req_ready_i) begin
          if (head_rd) begin
            state_nxt = WAIT_RSP;
          end else begin
            pop       = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid_i) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign in_req          = (state == REQ) && !rst_i;
  assign mem_req_valid_o = in_req;
  assign mem_rd_o        = in_req && head_rd;
  assign mem_wr_o        = in_req && head_wr;
  assign mem_addr_o      = in_req ? head_addr : '0;
  assign mem_line_o      = in_req ? head_line : '0;

  // Response lines are held until the same cache's next refill; valids pulse for one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ic_rsp_valid_o <= 1'b0;
      dc_rsp_valid_o <= 1'b0;
      ic_rsp_line_o  <= '0;
      dc_rsp_line_o  <= '0;
    end else begin
      ic_rsp_valid_o <= 1'b0;
      dc_rsp_valid_o <= 1'b0;
      if (state == WAIT_RSP && mem_rsp_valid_i) begin
        if (head_id == DCACHE) begin
          dc_rsp_valid_o <= 1'b1;
          dc_rsp_line_o  <= mem_rsp_line_i;
        end else begin
          ic_rsp_valid_o <= 1'b1;
          ic_rsp_line_o  <= mem_rsp_line_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Bench for segre_mem_arbiter: directed scenarios then random traffic against a queue-based model.
// Honours SEGRE_ARB_ROUND_ROBIN_EN when the design is built with it.
module tb_segre_mem_arbiter;

  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int LW    = 128;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          ic_req_valid_i = 1'b0;
  logic [AW-1:0] ic_addr_i = '0;
  logic          ic_req_ready_o;
  logic          dc_req_valid_i = 1'b0;
  logic          dc_rd_i = 1'b0;
  logic          dc_wr_i = 1'b0;
  logic [AW-1:0] dc_addr_i = '0;
  logic [LW-1:0] dc_line_i = '0;
  logic          dc_req_ready_o;
  logic          mem_req_valid_o;
  logic          mem_rd_o;
  logic          mem_wr_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_line_o;
  logic          mem_req_ready_i = 1'b0;
  logic          mem_rsp_valid_i = 1'b0;
  logic [LW-1:0] mem_rsp_line_i = '0;
  logic          ic_rsp_valid_o;
  logic [LW-1:0] ic_rsp_line_o;
  logic          dc_rsp_valid_o;
  logic [LW-1:0] dc_rsp_line_o;

  always #5 clk = ~clk;

  segre_mem_arbiter #(.ARB_BUF_SIZE(DEPTH), .ADDR_SIZE(AW), .CACHE_LINE_SIZE_BITS(LW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ic_req_valid_i(ic_req_valid_i), .ic_addr_i(ic_addr_i), .ic_req_ready_o(ic_req_ready_o),
    .dc_req_valid_i(dc_req_valid_i), .dc_rd_i(dc_rd_i), .dc_wr_i(dc_wr_i),
    .dc_addr_i(dc_addr_i), .dc_line_i(dc_line_i), .dc_req_ready_o(dc_req_ready_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
    .mem_addr_o(mem_addr_o), .mem_line_o(mem_line_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_line_i(mem_rsp_line_i),
    .ic_rsp_valid_o(ic_rsp_valid_o), .ic_rsp_line_o(ic_rsp_line_o),
    .dc_rsp_valid_o(dc_rsp_valid_o), .dc_rsp_line_o(dc_rsp_line_o)
  );

  typedef struct {
    logic          dc;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] line;
  } req_t;

  // Model: every accepted, not-yet-completed request in arrival order; q[0] is the one memory sees.
  req_t          q[$];
  logic [AW:0]   issue_log[$];
  int            tests = 0;
  int            failures = 0;
  int            cyc = 0;
  int            gap = 0;
  int            ic_pulses = 0;
  int            dc_pulses = 0;
  int            issues = 0;
  int            rise_cycle = -100;
  int            acc_cycle = 0;
  bit            m_waiting = 0;
  bit            m_ic_pulse = 0;
  bit            m_dc_pulse = 0;
  bit            m_last_dc = 0;
  bit            m_ic_acc = 0;
  bit            m_dc_acc = 0;
  bit            s_dc_ready = 0;
  bit            s_ic_ready = 0;
  bit            s_prev_valid = 0;
  logic [LW-1:0] m_ic_line = '0;
  logic [LW-1:0] m_dc_line = '0;

  function automatic logic [LW-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic monitorAndModel();
    bit   ok;
    bit   exp_dc;
    bit   exp_ic;
    req_t e;
    ok = !rst_i && (q.size() < DEPTH);
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
    exp_dc = ok && (!ic_req_valid_i || !m_last_dc);
    exp_ic = ok && (!dc_req_valid_i || m_last_dc);
`else
    exp_dc = ok;
    exp_ic = ok && !dc_req_valid_i;
`endif
    checkOutput("dc_req_ready", dc_req_ready_o, exp_dc);
    checkOutput("ic_req_ready", ic_req_ready_o, exp_ic);
    checkOutput("ic_rsp_valid", ic_rsp_valid_o, m_ic_pulse);
    checkOutput("dc_rsp_valid", dc_rsp_valid_o, m_dc_pulse);
    checkOutput("ic_rsp_line", ic_rsp_line_o, m_ic_line);
    checkOutput("dc_rsp_line", dc_rsp_line_o, m_dc_line);
    s_dc_ready = dc_req_ready_o;
    s_ic_ready = ic_req_ready_o;
    if (ic_rsp_valid_o === 1'b1) ic_pulses++;
    if (dc_rsp_valid_o === 1'b1) dc_pulses++;

    if (mem_req_valid_o === 1'b1) begin
      if (q.size() > 0 && !m_waiting) begin
        checkOutput("mem_rd", mem_rd_o, q[0].rd);
        checkOutput("mem_wr", mem_wr_o, q[0].wr);
        checkOutput("mem_addr", mem_addr_o, q[0].addr);
        checkOutput("mem_line", mem_line_o, q[0].line);
      end else begin
        checkOutput("mem_req_valid", mem_req_valid_o, 1'b0);
      end
    end else begin
      checkOutput("mem_idle_fields", (|mem_line_o) | (|mem_addr_o) | mem_rd_o | mem_wr_o, 1'b0);
    end

    // A pending head may sit at most one cycle before memory sees it.
    if (!rst_i && q.size() > 0 && !m_waiting && mem_req_valid_o !== 1'b1) begin
      gap++;
      checkOutput("issue_gap", gap <= 1, 1'b1);
    end else begin
      gap = 0;
    end
    if (mem_req_valid_o === 1'b1 && !s_prev_valid) rise_cycle = cyc;
    s_prev_valid = (mem_req_valid_o === 1'b1);

    m_ic_acc   = ic_req_valid_i && exp_ic;
    m_dc_acc   = dc_req_valid_i && exp_dc;
    m_ic_pulse = 0;
    m_dc_pulse = 0;
    if (rst_i) begin
      q.delete();
      m_waiting = 0;
      m_ic_line = '0;
      m_dc_line = '0;
      m_last_dc = 0;
      gap       = 0;
      return;
    end
    if (m_waiting && mem_rsp_valid_i) begin
      e = q.pop_front();
      if (e.dc) begin
        m_dc_pulse = 1;
        m_dc_line  = mem_rsp_line_i;
      end else begin
        m_ic_pulse = 1;
        m_ic_line  = mem_rsp_line_i;
      end
      m_waiting = 0;
    end else if (mem_req_valid_o === 1'b1 && mem_req_ready_i && q.size() > 0 && !m_waiting) begin
      issue_log.push_back({mem_wr_o, mem_addr_o});
      issues++;
      if (q[0].wr) void'(q.pop_front());
      else         m_waiting = 1;
    end
    if (m_dc_acc) begin
      acc_cycle = cyc;
      if (dc_rd_i != dc_wr_i) begin
        e.dc = 1; e.rd = dc_rd_i; e.wr = dc_wr_i; e.addr = dc_addr_i; e.line = dc_line_i;
        q.push_back(e);
        m_last_dc = 1;
      end
    end
    if (m_ic_acc) begin
      acc_cycle = cyc;
      e.dc = 0; e.rd = 1; e.wr = 0; e.addr = ic_addr_i; e.line = '0;
      q.push_back(e);
      m_last_dc = 0;
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    monitorAndModel();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic pushDc(input logic rd, input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] line);
    int n = 0;
    dc_req_valid_i = 1; dc_rd_i = rd; dc_wr_i = wr; dc_addr_i = addr; dc_line_i = line;
    do begin
      applyStimulus();
      n++;
    end while (!m_dc_acc && n < 40);
    checkOutput("dc_push_accepted", m_dc_acc, 1'b1);
    dc_req_valid_i = 0;
  endtask

  task automatic pushIc(input logic [AW-1:0] addr);
    int n = 0;
    ic_req_valid_i = 1; ic_addr_i = addr;
    do begin
      applyStimulus();
      n++;
    end while (!m_ic_acc && n < 40);
    checkOutput("ic_push_accepted", m_ic_acc, 1'b1);
    ic_req_valid_i = 0;
  endtask

  task automatic respondRead(input logic [LW-1:0] line);
    int n = 0;
    while (!m_waiting && n < 60) begin
      applyStimulus();
      n++;
    end
    checkOutput("rsp_wait_timeout", m_waiting, 1'b1);
    mem_rsp_valid_i = 1; mem_rsp_line_i = line;
    applyStimulus();
    mem_rsp_valid_i = 0;
  endtask

  task automatic drain();
    int n = 0;
    ic_req_valid_i = 0; dc_req_valid_i = 0; mem_req_ready_i = 1;
    while (q.size() > 0 && n < 600) begin
      mem_rsp_valid_i = m_waiting;
      mem_rsp_line_i  = rand128();
      applyStimulus();
      n++;
    end
    mem_rsp_valid_i = 0;
    runCycles(2);
    checkOutput("drain_empty", q.size(), 0);
  endtask

  initial begin
    int          ip0, dp0, is0, base, dcnt, n;
    logic [3:0]  grants;
    logic [3:0]  exp_grants;
    logic [2:0]  kind;

    rst_i = 1;
    runCycles(2);
    rst_i = 0;
    applyStimulus();
    checkOutput("reset_mem_valid", mem_req_valid_o, 1'b0);
    checkOutput("reset_ic_line", ic_rsp_line_o, '0);

    // Single icache read
    mem_req_ready_i = 1;
    ip0 = ic_pulses; dp0 = dc_pulses; rise_cycle = -100;
    pushIc(32'h0000_1040);
    runCycles(2);
    checkOutput("issue_latency", rise_cycle - acc_cycle, 2);
    checkOutput("issue_rd", issue_log[issue_log.size()-1], {1'b0, 32'h0000_1040});
    respondRead(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    runCycles(2);
    checkOutput("ic_pulse_count", ic_pulses - ip0, 1);
    checkOutput("dc_pulse_none", dc_pulses - dp0, 0);
    checkOutput("ic_line_value", ic_rsp_line_o, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);

    // Malformed dcache request is acknowledged but never reaches memory
    is0 = issues;
    pushDc(1, 1, 32'h900, rand128());
    checkOutput("bad_req_ready", s_dc_ready, 1'b1);
    runCycles(6);
    checkOutput("bad_req_no_issue", issues - is0, 0);

    // Write then read, issued in order
    base = issue_log.size(); ip0 = ic_pulses; dp0 = dc_pulses;
    pushDc(0, 1, 32'h200, 128'h1111_2222);
    pushIc(32'h300);
    respondRead(128'h5555_AAAA);
    runCycles(2);
    checkOutput("order_first_write", issue_log[base], {1'b1, 32'h200});
    checkOutput("order_second_read", issue_log[base+1], {1'b0, 32'h300});
    checkOutput("write_no_rsp", dc_pulses - dp0, 0);
    checkOutput("read_rsp", ic_pulses - ip0, 1);

    // Fill the FIFO while memory stalls, then drain in order (pointers wrap)
    mem_req_ready_i = 0;
    for (int i = 0; i < DEPTH; i++) pushDc(1, 0, 32'h1000 + 32'(i * 16), '0);
    dc_req_valid_i = 1; dc_rd_i = 1; dc_wr_i = 0; dc_addr_i = 32'h2000;
    ic_req_valid_i = 1; ic_addr_i = 32'h5000;
    applyStimulus();
    checkOutput("full_dc_ready", s_dc_ready, 1'b0);
    checkOutput("full_ic_ready", s_ic_ready, 1'b0);
    dc_req_valid_i = 0; ic_req_valid_i = 0;
    mem_req_ready_i = 1;
    dp0 = dc_pulses;
    for (int i = 0; i < DEPTH; i++) respondRead({4{32'hA5A5_0000 + 32'(i)}});
    runCycles(2);
    checkOutput("full_rsp_count", dc_pulses - dp0, DEPTH);
    checkOutput("full_last_addr", issue_log[issue_log.size()-1], {1'b0, 32'h10F0});
    checkOutput("full_last_line", dc_rsp_line_o, {4{32'hA5A5_000F}});

    // Contention for four cycles
    rst_i = 1;
    applyStimulus();
    rst_i = 0;
    mem_req_ready_i = 0;
    ic_req_valid_i = 1; ic_addr_i = 32'h7000;
    dcnt = 0;
    dc_req_valid_i = 1; dc_rd_i = 1; dc_wr_i = 0; dc_addr_i = 32'h8000;
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      grants[3-k] = s_dc_ready;
      if (m_dc_acc) begin
        dcnt++;
        dc_addr_i = 32'h8000 + 32'(dcnt * 16);
      end
      if (m_ic_acc) ic_addr_i = ic_addr_i + 32'h10;
    end
`ifdef SEGRE_ARB_ROUND_ROBIN_EN
    exp_grants = 4'b1010;
`else
    exp_grants = 4'b1111;
`endif
    checkOutput("contention_grants", grants, exp_grants);
    dc_req_valid_i = 0;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!m_ic_acc && n < 5);
    checkOutput("ic_after_contention", m_ic_acc, 1'b1);
    ic_req_valid_i = 0;
    drain();

    // Reset while a read is outstanding with three more queued
    mem_req_ready_i = 1;
    for (int i = 0; i < 4; i++) pushDc(1, 0, 32'hC000 + 32'(i * 16), '0);
    checkOutput("inflight_waiting", m_waiting, 1'b1);
    rst_i = 1;
    applyStimulus();
    rst_i = 0;
    ip0 = ic_pulses; dp0 = dc_pulses; is0 = issues;
    mem_rsp_valid_i = 1; mem_rsp_line_i = rand128();
    applyStimulus();
    mem_rsp_valid_i = 0;
    runCycles(5);
    checkOutput("reset_no_ic_pulse", ic_pulses - ip0, 0);
    checkOutput("reset_no_dc_pulse", dc_pulses - dp0, 0);
    checkOutput("reset_no_issue", issues - is0, 0);
    checkOutput("reset_mem_idle", mem_req_valid_o, 1'b0);
    checkOutput("reset_dc_line_cleared", dc_rsp_line_o, '0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      if (!ic_req_valid_i && ($urandom % 4 == 0)) begin
        ic_req_valid_i = 1;
        ic_addr_i = $urandom() & 32'hFFFF_FFF0;
      end
      if (!dc_req_valid_i && ($urandom % 3 == 0)) begin
        kind = 3'($urandom % 8);
        dc_req_valid_i = 1;
        dc_rd_i = (kind == 0) || (kind >= 2 && kind < 5);
        dc_wr_i = (kind == 0) || (kind >= 5);
        dc_addr_i = $urandom() & 32'hFFFF_FFF0;
        dc_line_i = rand128();
      end
      mem_req_ready_i = ($urandom % 3 != 0);
      mem_rsp_valid_i = m_waiting ? ($urandom % 3 == 0) : ($urandom % 10 == 0);
      mem_rsp_line_i  = rand128();
      applyStimulus();
      if (m_ic_acc) ic_req_valid_i = 0;
      if (m_dc_acc) dc_req_valid_i = 0;
    end
    mem_rsp_valid_i = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
